// File: rtl/p2s_sched_pkg.sv
// p2s_sched_pkg: state type and parameter defaults shared by the p2s round-robin scheduler.
package p2s_sched_pkg;
   typedef enum logic [1:0] {IDLE, OFFER, BUSY} sched_state_t;
   localparam int N_DEF       = 4;
   localparam int M_DEF       = 4;
   localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/p2s_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin pick; searches ptr+1, ptr+2, ... modulo M for the first request.
module rr_pick #(
   parameter int M    = 4,
   parameter int ID_W = $clog2(M)
) (
   input  logic [M-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [M-1:0]    gnt_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      // descending scan so the closest index after ptr is written last and wins
      for (int k = M; k >= 1; k--) begin
         if (req_i[(int'(ptr_i) + k) % M]) begin
            idx_o = ID_W'((int'(ptr_i) + k) % M);
            any_o = 1'b1;
         end
      end
      gnt_o = any_o ? (M'(1) << idx_o) : '0;
   end
endmodule

// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin arbiter sharing one parallel-to-serial serializer among M requesters.
// Optional watchdog enabled by defining P2S_SCHED_TIMEOUT_EN.
module p2s_rr_scheduler
   import p2s_sched_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int M       = M_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int ID_W   = $clog2(M)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [M-1:0]    req_valid,
   input  logic [M*N-1:0]  req_data,
   output logic [M-1:0]    req_ready,
   output logic            p2s_par_valid,
   output logic [N-1:0]    p2s_par_data,
   input  logic            p2s_par_ready,
   input  logic            mon_ser_valid,
   input  logic            mon_ser_ready,
   output logic [ID_W-1:0] grant_id,
   output logic            busy,
   output logic            timeout_err
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (M < 2 || N < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("p2s_rr_scheduler: invalid parameter set");
   end

   sched_state_t    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d;
   logic [N-1:0]    hold_q, hold_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [M-1:0]    pick_gnt;
   logic [ID_W-1:0] pick_idx;
   logic            pick_any, beat, wd_exp;

   assign beat = mon_ser_valid & mon_ser_ready;

   rr_pick #(.M(M), .ID_W(ID_W)) u_pick (
      .req_i(req_valid),
      .ptr_i(rr_ptr_q),
      .gnt_o(pick_gnt),
      .idx_o(pick_idx),
      .any_o(pick_any)
   );

`ifdef P2S_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   assign wd_exp      = (state_q != IDLE) && (wd_cnt_q == WD_W'(TIMEOUT));
   assign timeout_err = wd_exp;
   assign wd_cnt_d    = (state_q == IDLE || state_d != state_q || beat) ? '0 : wd_cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) wd_cnt_q <= '0;
      else       wd_cnt_q <= wd_cnt_d;
`else
   assign wd_exp      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      hold_d    = hold_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         IDLE:
            if (pick_any) begin
               hold_d   = req_data[pick_idx*N +: N];
               grant_d  = pick_idx;
               rr_ptr_d = pick_idx;
               state_d  = OFFER;
            end
         OFFER:
            if (p2s_par_ready) begin
               bit_cnt_d = '0;
               state_d   = BUSY;
            end
         BUSY:
            if (beat) begin
               // last beat leaves BUSY instead of wrapping the counter
               if (bit_cnt_q == CW'(N - 1)) state_d = IDLE;
               else                         bit_cnt_d = bit_cnt_q + 1'b1;
            end
         default: state_d = IDLE;
      endcase
      if (wd_exp) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         rr_ptr_q  <= ID_W'(M - 1);
         grant_q   <= '0;
         hold_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         hold_q    <= hold_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign req_ready     = (state_q == IDLE) ? pick_gnt : '0;
   assign p2s_par_valid = (state_q == OFFER);
   assign p2s_par_data  = hold_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// tb_p2s_rr_scheduler: directed self-checking bench for p2s_rr_scheduler (N=4, M=4, TIMEOUT=8).
module tb_p2s_rr_scheduler;
   localparam int N = 4;
   localparam int M = 4;
`ifdef P2S_SCHED_TIMEOUT_EN
   localparam int STALL = 6;
`else
   localparam int STALL = 10;
`endif

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [M-1:0]   req_valid = '0;
   logic [M*N-1:0] req_data = '0;
   logic [M-1:0]   req_ready;
   logic           p2s_par_valid;
   logic [N-1:0]   p2s_par_data;
   logic           p2s_par_ready = 1'b0;
   logic           mon_ser_valid = 1'b0;
   logic           mon_ser_ready = 1'b0;
   logic [1:0]     grant_id;
   logic           busy;
   logic           timeout_err;

   int vectors = 0;
   int miscompares = 0;

   p2s_rr_scheduler #(.N(N), .M(M), .TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .p2s_par_valid(p2s_par_valid), .p2s_par_data(p2s_par_data), .p2s_par_ready(p2s_par_ready),
      .mon_ser_valid(mon_ser_valid), .mon_ser_ready(mon_ser_ready),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] words [4];
      int beats;
      int n;
      words = '{4'hC, 4'h6, 4'h9, 4'hD};
      cyc; cyc;
      chk("rst_busy", busy, 0);
      chk("rst_valid", p2s_par_valid, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_data", p2s_par_data, 0);
      chk("rst_tmo", timeout_err, 0);
      rstn = 1'b1;
      // T1: single requester 0 with word A
      req_valid = 4'b0001;
      req_data  = 16'h000A;
      #1;
      chk("t1_ready", req_ready, 4'b0001);
      cyc;
      chk("t1_valid", p2s_par_valid, 1);
      chk("t1_data", p2s_par_data, 4'hA);
      chk("t1_grant", grant_id, 0);
      chk("t1_busy", busy, 1);
      // T3: stalled serializer, other requesters pending, serial beats ignored in OFFER
      req_valid = 4'b1111;
      req_data  = 16'h555A;
      mon_ser_valid = 1'b1;
      mon_ser_ready = 1'b1;
      for (int k = 0; k < STALL; k++) begin
         cyc;
         chk("t3_valid", p2s_par_valid, 1);
         chk("t3_data", p2s_par_data, 4'hA);
         chk("t3_ready", req_ready, 0);
         chk("t3_tmo", timeout_err, 0);
      end
      p2s_par_ready = 1'b1;
      cyc;
      chk("t3_busy_state", busy, 1);
      chk("t3_valid_off", p2s_par_valid, 0);
      p2s_par_ready = 1'b0;
      req_valid = 4'b0000;
      // T4: ready toggling; only ready=1 edges count, IDLE after 4th beat
      beats = 0;
      for (int k = 0; k < 7; k++) begin
         mon_ser_ready = (k % 2 == 0);
         cyc;
         if (k % 2 == 0) beats++;
         chk("t4_busy", busy, (beats < 4) ? 1 : 0);
         chk("t4_valid", p2s_par_valid, 0);
      end
      chk("t4_grant_kept", grant_id, 0);
      // T5: reset in the middle of a word
      mon_ser_valid = 1'b0;
      mon_ser_ready = 1'b0;
      req_valid = 4'b0100;
      req_data  = 16'h0B00;
      p2s_par_ready = 1'b1;
      #1;
      chk("t5_ready", req_ready, 4'b0100);
      cyc;
      chk("t5_grant", grant_id, 2);
      chk("t5_data", p2s_par_data, 4'hB);
      cyc;
      p2s_par_ready = 1'b0;
      mon_ser_valid = 1'b1;
      mon_ser_ready = 1'b1;
      cyc; cyc;
      chk("t5_mid_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_valid", p2s_par_valid, 0);
      chk("t5_rst_grant", grant_id, 0);
      chk("t5_rst_data", p2s_par_data, 0);
      cyc;
      rstn = 1'b1;
      // T2: all requesters and serializer always ready
      req_valid = 4'b1111;
      req_data  = 16'hD96C;
      p2s_par_ready = 1'b1;
      #1;
      for (int w = 0; w < 5; w++) begin
         chk("t2_ready", req_ready, 1 << (w % 4));
         cyc;
         chk("t2_valid", p2s_par_valid, 1);
         chk("t2_grant", grant_id, w % 4);
         chk("t2_data", p2s_par_data, words[w % 4]);
         cyc;
         n = 0;
         while (busy && !p2s_par_valid && n < 20) begin
            n++;
            cyc;
         end
         chk("t2_beats", n, 4);
         chk("t2_idle", busy, 0);
      end
      // T6: serializer stuck in OFFER
      p2s_par_ready = 1'b0;
      mon_ser_valid = 1'b0;
      cyc;
      chk("t6_grant", grant_id, 1);
      chk("t6_valid", p2s_par_valid, 1);
      for (int k = 1; k <= 8; k++) begin
         cyc;
`ifdef P2S_SCHED_TIMEOUT_EN
         chk("t6_tmo", timeout_err, (k == 8) ? 1 : 0);
`else
         chk("t6_tmo", timeout_err, 0);
`endif
      end
      cyc;
`ifdef P2S_SCHED_TIMEOUT_EN
      chk("t6_idle", busy, 0);
      chk("t6_tmo_pulse", timeout_err, 0);
      chk("t6_next", req_ready, 4'b0100);
`else
      chk("t6_wait", busy, 1);
      chk("t6_hold", p2s_par_valid, 1);
      chk("t6_no_ready", req_ready, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
